// File: rtl/usb_tx_packetizer.sv
`default_nettype none
// ============================================================================
// usb_tx_packetizer : serializes ACK/NAK/DATAx packets with bit stuffing, NRZI
// Rev 1.0 - initial release
// ============================================================================
module usb_tx_packetizer #(
   parameter int BIT_DIV = 8
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tx_send_good,
   input  logic       tx_send_bad,
   input  logic       tx_transmit,
   input  logic [6:0] tx_len,
   input  logic [7:0] rd_data,
   input  logic       buf_empty,
   output logic       buf_rd,
   output logic       dp,
   output logic       dm,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int                 c_cnt_w     = $clog2(BIT_DIV);
   localparam logic [c_cnt_w-1:0] c_cnt_max   = c_cnt_w'(BIT_DIV - 1);
   localparam logic [7:0]         c_sync      = 8'h80;
   localparam logic [7:0]         c_pid_ack   = 8'hD2;
   localparam logic [7:0]         c_pid_nak   = 8'h5A;
   localparam logic [7:0]         c_pid_data0 = 8'hC3;
   localparam logic [7:0]         c_pid_data1 = 8'h4B;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SYNC = 3'd1,
      ST_PID  = 3'd2,
      ST_DATA = 3'd3,
      ST_CRC  = 3'd4,
      ST_EOP  = 3'd5
   } state_t;

   state_t             r_state,   w_state_nxt;
   logic [c_cnt_w-1:0] r_cnt,     w_cnt_nxt;
   logic [15:0]        r_shift,   w_shift_nxt;
   logic [3:0]         r_idx,     w_idx_nxt;
   logic [6:0]         r_left,    w_left_nxt;
   logic [15:0]        r_crc,     w_crc_nxt;
   logic [2:0]         r_ones,    w_ones_nxt;
   logic               r_stuff,   w_stuff_nxt;
   logic               r_line,    w_line_nxt;
   logic               r_se0,     w_se0_nxt;
   logic               r_toggle,  w_toggle_nxt;
   logic               r_is_data, w_is_data_nxt;
   logic               r_abort,   w_abort_nxt;
   logic               r_busy,    w_busy_nxt;
   logic               r_done,    w_done_nxt;
   logic               r_err,     w_err_nxt;
   logic               w_load;
   logic               w_tick, w_stuffable, w_need_stuff, w_payload_bit, w_crc_fb;
   logic [15:0]        w_crc_upd, w_crc_now;
   logic [7:0]         w_pid;
   logic [6:0]         w_len_clamped;

   assign w_tick        = (r_cnt == c_cnt_max);
   assign w_stuffable   = (r_state == ST_PID) || (r_state == ST_DATA) || (r_state == ST_CRC);
   assign w_need_stuff  = w_stuffable && !r_stuff && r_shift[0] && (r_ones == 3'd5);
   assign w_payload_bit = (r_state == ST_DATA) && !r_stuff;
   assign w_crc_fb      = r_crc[15] ^ r_shift[0];
   assign w_crc_upd     = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h8005 : 16'h0000);
   // CRC field may load on the same tick that folds in the last payload bit
   assign w_crc_now     = w_payload_bit ? w_crc_upd : r_crc;
   assign w_len_clamped = (tx_len > 7'd64) ? 7'd64 : tx_len;
   assign w_pid         = tx_send_bad  ? c_pid_nak :
                          tx_send_good ? c_pid_ack :
                          r_toggle     ? c_pid_data1 : c_pid_data0;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_shift   <= '0;
         r_idx     <= '0;
         r_left    <= '0;
         r_crc     <= 16'hFFFF;
         r_ones    <= '0;
         r_stuff   <= 1'b0;
         r_line    <= 1'b1;
         r_se0     <= 1'b0;
         r_toggle  <= 1'b0;
         r_is_data <= 1'b0;
         r_abort   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_shift   <= w_shift_nxt;
         r_idx     <= w_idx_nxt;
         r_left    <= w_left_nxt;
         r_crc     <= w_crc_nxt;
         r_ones    <= w_ones_nxt;
         r_stuff   <= w_stuff_nxt;
         r_line    <= w_line_nxt;
         r_se0     <= w_se0_nxt;
         r_toggle  <= w_toggle_nxt;
         r_is_data <= w_is_data_nxt;
         r_abort   <= w_abort_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_shift_nxt   = r_shift;
      w_idx_nxt     = r_idx;
      w_left_nxt    = r_left;
      w_crc_nxt     = r_crc;
      w_ones_nxt    = r_ones;
      w_stuff_nxt   = r_stuff;
      w_line_nxt    = r_line;
      w_se0_nxt     = r_se0;
      w_toggle_nxt  = r_toggle;
      w_is_data_nxt = r_is_data;
      w_abort_nxt   = r_abort;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b0;
      w_load        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (tx_send_bad || tx_send_good || tx_transmit) begin
               w_state_nxt   = ST_SYNC;
               w_busy_nxt    = 1'b1;
               w_shift_nxt   = {w_pid, c_sync};
               w_idx_nxt     = '0;
               w_ones_nxt    = '0;
               w_stuff_nxt   = 1'b0;
               w_se0_nxt     = 1'b0;
               w_abort_nxt   = 1'b0;
               w_crc_nxt     = 16'hFFFF;
               w_is_data_nxt = !tx_send_bad && !tx_send_good;
               w_left_nxt    = w_len_clamped;
               w_line_nxt    = ~r_line;
            end
         end
         default: begin
            w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
               if (r_state != ST_EOP && !r_stuff) begin
                  w_ones_nxt = r_shift[0] ? r_ones + 3'd1 : 3'd0;
                  if (w_payload_bit)
                     w_crc_nxt = w_crc_upd;
               end
               if (w_need_stuff) begin
                  // field progress is frozen for one bit time while the stuffed 0 goes out
                  w_stuff_nxt = 1'b1;
                  w_line_nxt  = ~r_line;
               end else begin
                  w_stuff_nxt = 1'b0;
                  if (r_stuff)
                     w_ones_nxt = '0;
                  w_shift_nxt = r_shift >> 1;
                  w_idx_nxt   = r_idx + 4'd1;
                  case (r_state)
                     ST_SYNC: begin
                        if (r_idx == 4'd7) begin
                           w_state_nxt = ST_PID;
                           w_idx_nxt   = '0;
                        end
                     end
                     ST_PID, ST_DATA: begin
                        if (r_idx == 4'd7) begin
                           w_idx_nxt = '0;
                           if (r_state == ST_PID && !r_is_data) begin
                              w_state_nxt = ST_EOP;
                              w_se0_nxt   = 1'b1;
                           end else if (r_left == '0) begin
                              w_state_nxt = ST_CRC;
                              w_shift_nxt = ~w_crc_now;
                           end else if (buf_empty) begin
                              w_state_nxt = ST_EOP;
                              w_se0_nxt   = 1'b1;
                              w_abort_nxt = 1'b1;
                           end else begin
                              w_state_nxt = ST_DATA;
                              w_shift_nxt = {8'h00, rd_data};
                              w_load      = 1'b1;
                              w_left_nxt  = r_left - 7'd1;
                           end
                        end
                     end
                     ST_CRC: begin
                        if (r_idx == 4'd15) begin
                           w_state_nxt = ST_EOP;
                           w_se0_nxt   = 1'b1;
                           w_idx_nxt   = '0;
                        end
                     end
                     ST_EOP: begin
                        if (r_idx == 4'd1) begin
                           w_se0_nxt  = 1'b0;
                           w_line_nxt = 1'b1;
                        end else if (r_idx == 4'd2) begin
                           w_state_nxt = ST_IDLE;
                           w_idx_nxt   = '0;
                           w_busy_nxt  = 1'b0;
                           w_done_nxt  = !r_abort;
                           w_err_nxt   = r_abort;
                           if (r_is_data && !r_abort)
                              w_toggle_nxt = ~r_toggle;
                        end
                     end
                     default: ;
                  endcase
                  if (w_state_nxt != ST_EOP && w_state_nxt != ST_IDLE)
                     w_line_nxt = w_shift_nxt[0] ? r_line : ~r_line;
               end
            end
         end
      endcase
   end

   assign buf_rd  = w_load && n_rst;
   assign dp      = r_line && !r_se0;
   assign dm      = !r_line && !r_se0;
   assign tx_busy = r_busy;
   assign tx_done = r_done;
   assign tx_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_packetizer.sv
`default_nettype none
// ============================================================================
// tb_usb_tx_packetizer : scoreboard bench, line symbols sampled mid bit time
// Rev 1.0 - initial release
// ============================================================================
module tb_usb_tx_packetizer;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       tx_send_good = 1'b0;
   logic       tx_send_bad = 1'b0;
   logic       tx_transmit = 1'b0;
   logic [6:0] tx_len = '0;
   logic [7:0] rd_data = '0;
   logic       buf_empty = 1'b1;
   logic       buf_rd, dp, dm, tx_busy, tx_done, tx_err;

   logic [1:0] exp_q[$];
   logic [7:0] buf_q[$];
   logic [7:0] pay[64];
   int         n_cmp = 0;
   int         n_mis = 0;
   int         n_done = 0;
   int         n_errp = 0;
   int         n_rd = 0;
   bit         rd_pending = 1'b0;
   logic       exp_toggle = 1'b0;
   logic       m_line;
   int         m_ones;

   usb_tx_packetizer #(.BIT_DIV(8)) dut (
      .clk(clk), .n_rst(n_rst), .tx_send_good(tx_send_good), .tx_send_bad(tx_send_bad),
      .tx_transmit(tx_transmit), .tx_len(tx_len), .rd_data(rd_data), .buf_empty(buf_empty),
      .buf_rd(buf_rd), .dp(dp), .dm(dm), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
   );

   always #5 clk = ~clk;

   // FWFT buffer: a pop seen mid-cycle takes effect after the capturing edge
   always @(negedge clk) begin
      if (rd_pending && buf_q.size() > 0)
         void'(buf_q.pop_front());
      rd_pending = buf_rd;
      if (buf_rd)  n_rd++;
      if (tx_done) n_done++;
      if (tx_err)  n_errp++;
      buf_empty = (buf_q.size() == 0);
      rd_data   = (buf_q.size() > 0) ? buf_q[0] : 8'h00;
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic add_bit(input logic b, input bit stf);
      if (!b) m_line = ~m_line;
      exp_q.push_back({m_line, ~m_line});
      m_ones = b ? m_ones + 1 : 0;
      if (stf && m_ones == 6) begin
         m_line = ~m_line;
         exp_q.push_back({m_line, ~m_line});
         m_ones = 0;
      end
   endtask

   task automatic add_byte(input logic [7:0] v, input bit stf);
      for (int i = 0; i < 8; i++) add_bit(v[i], stf);
   endtask

   // kind: 0 ACK, 1 NAK, 2 DATA, 3 NAK+DATA same cycle
   task automatic run_pkt(input int kind, input int len, input int n_avail,
                          input bit inject, input int want_bits);
      logic [7:0]  pid;
      logic [15:0] crc, crc_tx;
      logic [1:0]  e;
      bit          is_data, abort, seen, fb, busy_seen;
      int          n, rd_exp, nsym, cyc, d0, e0, r0;
      is_data = (kind == 2);
      pid     = (kind == 0) ? 8'hD2 : (kind == 2) ? (exp_toggle ? 8'h4B : 8'hC3) : 8'h5A;
      n       = (len > 64) ? 64 : len;
      rd_exp  = 0;
      abort   = 1'b0;
      m_line  = 1'b1;
      m_ones  = 0;
      exp_q.delete();
      add_byte(8'h80, 1'b0);
      add_byte(pid, 1'b1);
      if (is_data) begin
         crc = 16'hFFFF;
         for (int i = 0; i < n; i++) begin
            if (i >= n_avail) begin
               abort = 1'b1;
               break;
            end
            add_byte(pay[i], 1'b1);
            rd_exp++;
            for (int j = 0; j < 8; j++) begin
               fb  = crc[15] ^ pay[i][j];
               crc = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
         end
         if (!abort) begin
            crc_tx = ~crc;
            for (int j = 0; j < 16; j++) add_bit(crc_tx[j], 1'b1);
         end
         for (int i = 0; i < n_avail; i++) buf_q.push_back(pay[i]);
      end
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b10);
      nsym = exp_q.size();
      d0 = n_done; e0 = n_errp; r0 = n_rd;

      @(negedge clk);
      tx_send_good = (kind == 0);
      tx_send_bad  = (kind == 1) || (kind == 3);
      tx_transmit  = (kind >= 2);
      tx_len       = 7'(len);
      @(negedge clk);
      tx_send_good = 1'b0; tx_send_bad = 1'b0; tx_transmit = 1'b0;
      chk_eq("busy_rise", 32'(tx_busy), 32'd1);
      repeat (3) @(negedge clk);
      cyc = 3;
      for (int k = 0; k < nsym; k++) begin
         e = exp_q.pop_front();
         chk_eq($sformatf("line[%0d]", k), 32'({dp, dm}), 32'(e));
         if (k < nsym - 1) begin
            for (int s = 0; s < 8; s++) begin
               if (inject && k == 5 && s == 0) begin
                  tx_transmit = 1'b1; tx_send_good = 1'b1; tx_len = 7'd3;
               end
               @(negedge clk);
               cyc++;
               if (inject && k == 5 && s == 0) begin
                  tx_transmit = 1'b0; tx_send_good = 1'b0;
               end
            end
         end
      end
      chk_eq("busy_hold", 32'(tx_busy), 32'd1);
      seen = 1'b0;
      while (!seen && cyc < 8 * nsym + 16) begin
         @(negedge clk);
         cyc++;
         seen = tx_done || tx_err;
      end
      chk_eq("end_seen", 32'(seen), 32'd1);
      chk_eq("duration", 32'(cyc), 32'(8 * nsym));
      if (want_bits > 0) chk_eq("bit_times", 32'(cyc), 32'(8 * want_bits));
      chk_eq("done_pulse", 32'(tx_done), 32'(!abort));
      chk_eq("err_pulse", 32'(tx_err), 32'(abort));
      chk_eq("busy_fall", 32'(tx_busy), 32'd0);
      chk_eq("idle_j", 32'({dp, dm}), 32'd2);
      repeat (2) @(negedge clk);
      chk_eq("done_count", 32'(n_done - d0), 32'(!abort));
      chk_eq("err_count", 32'(n_errp - e0), 32'(abort));
      chk_eq("rd_count", 32'(n_rd - r0), 32'(rd_exp));
      if (is_data && !abort) exp_toggle = ~exp_toggle;
      if (inject) begin
         busy_seen = 1'b0;
         repeat (20) begin
            @(negedge clk);
            if (tx_busy) busy_seen = 1'b1;
         end
         chk_eq("no_restart", 32'(busy_seen), 32'd0);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0, e0;
      repeat (4) @(negedge clk);
      chk_eq("rst_line", 32'({dp, dm}), 32'd2);
      chk_eq("rst_busy", 32'(tx_busy), 32'd0);
      chk_eq("rst_pulses", 32'({tx_done, tx_err, buf_rd}), 32'd0);
      n_rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_eq("idle_line", 32'({dp, dm}), 32'd2);

      run_pkt(0, 0, 0, 1'b0, 19);
      run_pkt(2, 0, 0, 1'b0, 35);
      run_pkt(2, 0, 0, 1'b0, 35);

      pay[0] = 8'hFF; pay[1] = 8'h01;
      run_pkt(2, 2, 2, 1'b0, 0);

      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
      run_pkt(2, 4, 2, 1'b0, 0);
      pay[0] = 8'hA5;
      run_pkt(2, 1, 1, 1'b0, 0);

      run_pkt(3, 5, 0, 1'b1, 19);

      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom_range(0, 255));
      pay[10] = 8'hFF; pay[11] = 8'hFF;
      run_pkt(2, 100, 64, 1'b0, 0);

      for (int i = 0; i < 3; i++) begin
         pay[i] = 8'(i * 17 + 3);
         buf_q.push_back(pay[i]);
      end
      d0 = n_done; e0 = n_errp;
      @(negedge clk);
      tx_transmit = 1'b1; tx_len = 7'd3;
      @(negedge clk);
      tx_transmit = 1'b0;
      repeat (8 * 20) @(negedge clk);
      chk_eq("busy_pre_rst", 32'(tx_busy), 32'd1);
      n_rst = 1'b0;
      @(negedge clk);
      chk_eq("mid_rst_line", 32'({dp, dm}), 32'd2);
      chk_eq("mid_rst_busy", 32'(tx_busy), 32'd0);
      chk_eq("mid_rst_pulses", 32'({tx_done, tx_err, buf_rd}), 32'd0);
      n_rst = 1'b1;
      repeat (40) @(negedge clk);
      chk_eq("mid_rst_no_done", 32'(n_done - d0), 32'd0);
      chk_eq("mid_rst_no_err", 32'(n_errp - e0), 32'd0);
      chk_eq("mid_rst_idle", 32'(tx_busy), 32'd0);
      buf_q.delete();
      exp_toggle = 1'b0;
      run_pkt(2, 0, 0, 1'b0, 35);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/usb_tx_packetizer.md
USB_TX_PACKETIZER -- requirements
Module: usb_tx_packetizer

Interface
REQ-001 SHALL have parameter: BIT_DIV, 8, clock cycles per USB bit time (>=4).
REQ-002 SHALL have ports:
  clk  in  1  system clock, all logic on rising edge
  n_rst  in  1  synchronous active-low reset
  tx_send_good  in  1  request ACK handshake packet
  tx_send_bad  in  1  request NAK handshake packet
  tx_transmit  in  1  request DATA packet
  tx_len  in  7  DATA payload byte count 0..64, sampled with tx_transmit
  rd_data  in  8  first-word-fall-through payload byte from buffer
  buf_empty  in  1  payload buffer empty
  buf_rd  out  1  one-cycle pop strobe to buffer
  dp  out  1  D+ line
  dm  out  1  D- line
  tx_busy  out  1  packet in progress
  tx_done  out  1  one-cycle pulse, packet completed
  tx_err  out  1  one-cycle pulse, packet aborted on underrun

Function
REQ-003 SHALL implement states IDLE, SYNC, PID, DATA, CRC, EOP; all serial bits advance on a bit-tick every BIT_DIV clocks, counter restarted on leaving IDLE.
REQ-004 SHALL accept requests only in IDLE; priority tx_send_bad > tx_send_good > tx_transmit; requests while tx_busy ignored.
REQ-005 SHALL assert tx_busy the cycle after request acceptance until the cycle tx_done or tx_err pulses (inclusive deassert that cycle).
REQ-006 SHALL send SYNC 0x80, then PID byte: ACK 0xD2, NAK 0x5A, DATA0 0xC3, DATA1 0x4B; all bytes LSB first.
REQ-007 SHALL, for DATA, send tx_len payload bytes then 16-bit CRC, LSB first; handshakes go PID -> EOP.
REQ-008 SHALL compute CRC16 poly 0x8005, init 0xFFFF, over payload bits LSB first; transmitted value is bitwise complement.
REQ-009 SHALL pulse buf_rd for one clock when each payload byte is loaded into the shift register, capturing rd_data that cycle.
REQ-010 SHALL NRZI encode: data 0 toggles line state, data 1 holds; J = dp1/dm0, K = dp0/dm1.
REQ-011 SHALL insert a stuffed 0 after six consecutive 1s in PID, DATA and CRC fields; stuff counter reset by any 0 and at SYNC start; stuffed bits take one bit time and do not enter CRC.
REQ-012 SHALL drive EOP as SE0 (dp0/dm0) for 2 bit times, then J for 1 bit time, then return to IDLE.
REQ-013 SHALL pulse tx_done one clock at end of EOP J bit time.
REQ-014 SHALL hold a data toggle, DATA0 after reset, flipped only on tx_done of a DATA packet; handshakes and aborts leave it unchanged.
REQ-015 SHALL, if buf_empty when a payload byte must load, skip remaining DATA/CRC, enter EOP at next bit-tick, pulse tx_err (not tx_done) at end of EOP.
REQ-016 SHALL treat tx_len 0 as zero-length packet (CRC field 0x0000); tx_len >64 clamped to 64.
REQ-017 SHALL hold dp1/dm0 (idle J) in IDLE.

Reset
REQ-018 SHALL, on n_rst low at clk edge, force IDLE regardless of state: dp1, dm0, tx_busy0, tx_done0, tx_err0, buf_rd0, toggle DATA0, bit/stuff counters 0; no done/err pulse for an interrupted packet.

Verification
REQ-019 tx_send_good pulse -> SYNC, PID 0xD2, EOP; 19 bit times (152 clk at BIT_DIV 8); single tx_done; line returns to J.
REQ-020 tx_transmit tx_len 0 twice -> first PID 0xC3 CRC 0x0000, second PID 0x4B; 35 bit times each; zero buf_rd.
REQ-021 tx_transmit tx_len 2, bytes 0xFF,0x01 -> stuffed 0 after 6th 1; exactly 2 buf_rd pulses; CRC matches reference model.
REQ-022 tx_transmit tx_len 4, buf_empty asserted before 3rd byte -> 2 buf_rd, EOP, tx_err pulse, no tx_done, next DATA still uses same toggle.
REQ-023 tx_send_bad and tx_transmit same cycle -> NAK 0x5A sent, DATA request dropped; request during busy ignored.
REQ-024 n_rst low mid-DATA -> next clock dp1/dm0, tx_busy0, no pulses, toggle DATA0.
